// File: rtl/lcd_cmd_pkg.sv
// ILI9341 opcodes, default panel geometry and fill-engine state encoding
// shared by the rectangle fill engine and its byte transmitter.
package lcd_cmd_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int unsigned LCD_WIDTH  = 240;
   localparam int unsigned LCD_HEIGHT = 320;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_CASET_C = 4'd1;
   localparam logic [3:0] ST_CASET_D = 4'd2;
   localparam logic [3:0] ST_PASET_C = 4'd3;
   localparam logic [3:0] ST_PASET_D = 4'd4;
   localparam logic [3:0] ST_RAMWR_C = 4'd5;
   localparam logic [3:0] ST_PIX_HI  = 4'd6;
   localparam logic [3:0] ST_PIX_LO  = 4'd7;
   localparam logic [3:0] ST_FINISH  = 4'd8;

   // Coordinates go out zero-extended to 16 bits, high byte first.
   function automatic logic [7:0] coord_byte(input logic [8:0] c, input logic lo);
      return lo ? c[7:0] : {7'b0, c[8]};
   endfunction

endpackage

// File: rtl/lcd_rect_fill_if.sv
// Byte-level link between the fill engine (master) and the LCD byte controller (slave).
interface lcd_rect_fill_if;

   logic       LCD_LOAD;
   logic       LCD_IS_CMD;
   logic [7:0] LCD_DATA;
   logic       LCD_BUSY;
   logic       LCD_READY;

   modport master (output LCD_LOAD, LCD_IS_CMD, LCD_DATA, input LCD_BUSY, LCD_READY);
   modport slave  (input LCD_LOAD, LCD_IS_CMD, LCD_DATA, output LCD_BUSY, LCD_READY);

endinterface

// File: rtl/lcd_byte_tx.sv
// One-byte LOAD/BUSY handshake towards the LCD controller: hold the byte until
// BUSY is seen, then wait for BUSY to drop before another byte can be taken.
module lcd_byte_tx
   import lcd_cmd_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            send_i,
   input  logic            is_cmd_i,
   input  logic [7:0]      data_i,
   output logic            accepted_o,
   output logic            idle_o,
   lcd_rect_fill_if.master lcd
);

   logic       load_q, load_d;
   logic       cmd_q, cmd_d;
   logic [7:0] data_q, data_d;

   always_comb begin
      load_d = load_q;
      cmd_d  = cmd_q;
      data_d = data_q;
      if (load_q) begin
         if (lcd.LCD_BUSY) load_d = 1'b0;
      end else if (send_i && !lcd.LCD_BUSY) begin
         load_d = 1'b1;
         cmd_d  = is_cmd_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_q <= 1'b0;
         cmd_q  <= 1'b0;
         data_q <= '0;
      end else begin
         load_q <= load_d;
         cmd_q  <= cmd_d;
         data_q <= data_d;
      end
   end

   assign accepted_o     = load_q & lcd.LCD_BUSY;
   assign idle_o         = !load_q && !lcd.LCD_BUSY;
   assign lcd.LCD_LOAD   = load_q;
   assign lcd.LCD_IS_CMD = cmd_q;
   assign lcd.LCD_DATA   = data_q;

endmodule

// File: rtl/lcd_rect_fill.sv
// Solid-colour rectangle fill: CASET, PASET, RAMWR, then N RGB565 pixels.
// Define LCD_RECT_FILL_CLIP_EN to clamp X1/Y1 to the panel and reject off-panel X0/Y0.
module lcd_rect_fill
   import lcd_cmd_pkg::*;
#(
   parameter int unsigned WIDTH  = LCD_WIDTH,
   parameter int unsigned HEIGHT = LCD_HEIGHT
) (
   input  logic            CLK_100MHz,
   input  logic            RESET,
   input  logic            START,
   input  logic [8:0]      X0,
   input  logic [8:0]      X1,
   input  logic [8:0]      Y0,
   input  logic [8:0]      Y1,
   input  logic [15:0]     COLOR,
   output logic            BUSY,
   output logic            DONE,
   output logic            ERR,
   lcd_rect_fill_if.master lcd
);

   localparam int unsigned PIX_W = $clog2(WIDTH * HEIGHT + 1);

   logic [3:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [8:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [15:0]      color_q, color_d;
   logic [PIX_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [8:0] x1_c, y1_c;
   logic [9:0] w, h;
   logic       reject;
   logic       tx_send, tx_is_cmd, tx_accepted, tx_idle;
   logic [7:0] tx_data;

`ifdef LCD_RECT_FILL_CLIP_EN
   localparam logic [8:0] X_MAX = 9'(WIDTH - 1);
   localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);

   always_comb begin
      x1_c   = (X1 > X_MAX) ? X_MAX : X1;
      y1_c   = (Y1 > Y_MAX) ? Y_MAX : Y1;
      reject = (X0 > X_MAX) || (Y0 > Y_MAX) || (X0 > x1_c) || (Y0 > y1_c);
   end
`else
   always_comb begin
      x1_c   = X1;
      y1_c   = Y1;
      reject = (X0 > X1) || (Y0 > Y1);
   end
`endif

   assign w = {1'b0, x1_c} - {1'b0, X0} + 10'd1;
   assign h = {1'b0, y1_c} - {1'b0, Y0} + 10'd1;

   always_comb begin
      tx_is_cmd = 1'b0;
      tx_data   = '0;
      case (state_q)
         ST_CASET_C: begin tx_is_cmd = 1'b1; tx_data = CMD_CASET; end
         ST_CASET_D: tx_data = coord_byte(idx_q[1] ? x1_q : x0_q, idx_q[0]);
         ST_PASET_C: begin tx_is_cmd = 1'b1; tx_data = CMD_PASET; end
         ST_PASET_D: tx_data = coord_byte(idx_q[1] ? y1_q : y0_q, idx_q[0]);
         ST_RAMWR_C: begin tx_is_cmd = 1'b1; tx_data = CMD_RAMWR; end
         ST_PIX_HI:  tx_data = color_q[15:8];
         ST_PIX_LO:  tx_data = color_q[7:0];
         default:    tx_data = '0;
      endcase
   end

   assign tx_send = (state_q != ST_IDLE) && (state_q != ST_FINISH) && tx_idle;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      color_d = color_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (START && lcd.LCD_READY) begin
            if (reject) begin
               err_d = 1'b1;
            end else begin
               x0_d    = X0;
               x1_d    = x1_c;
               y0_d    = Y0;
               y1_d    = y1_c;
               color_d = COLOR;
               cnt_d   = PIX_W'(w) * PIX_W'(h);
               busy_d  = 1'b1;
               state_d = ST_CASET_C;
            end
         end
         ST_CASET_C: if (tx_accepted) begin idx_d = '0; state_d = ST_CASET_D; end
         ST_CASET_D: if (tx_accepted) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_PASET_C;
         end
         ST_PASET_C: if (tx_accepted) begin idx_d = '0; state_d = ST_PASET_D; end
         ST_PASET_D: if (tx_accepted) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_RAMWR_C;
         end
         ST_RAMWR_C: if (tx_accepted) state_d = ST_PIX_HI;
         ST_PIX_HI:  if (tx_accepted) state_d = ST_PIX_LO;
         ST_PIX_LO:  if (tx_accepted) begin
            cnt_d   = cnt_q - PIX_W'(1);
            state_d = (cnt_q == PIX_W'(1)) ? ST_FINISH : ST_PIX_HI;
         end
         ST_FINISH: if (tx_idle) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_100MHz) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         color_q <= color_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;

   lcd_byte_tx u_tx (
      .clk        (CLK_100MHz),
      .rst        (RESET),
      .send_i     (tx_send),
      .is_cmd_i   (tx_is_cmd),
      .data_i     (tx_data),
      .accepted_o (tx_accepted),
      .idle_o     (tx_idle),
      .lcd        (lcd)
   );

endmodule

// File: tb/tb_lcd_rect_fill.sv
// Randomised bench for lcd_rect_fill: an LCD controller stub captures the byte
// stream, which is compared against a byte list built from the rectangle request.
`timescale 1ns/1ps
module tb_lcd_rect_fill;

   localparam int TB_W = 240;
   localparam int TB_H = 320;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  x0, x1, y0, y1;
   logic [15:0] color;
   logic        busy, done, err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   lcd_rect_fill_if lif ();

   lcd_rect_fill #(.WIDTH(TB_W), .HEIGHT(TB_H)) dut (
      .CLK_100MHz (clk),
      .RESET      (rst),
      .START      (start),
      .X0         (x0),
      .X1         (x1),
      .Y0         (y0),
      .Y1         (y1),
      .COLOR      (color),
      .BUSY       (busy),
      .DONE       (done),
      .ERR        (err),
      .lcd        (lif)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // LCD stub: BUSY rises 3 cycles after LOAD is seen, falls 20 cycles later.
   logic        stub_busy = 1'b0;
   bit          stub_pend = 1'b0;
   int unsigned stub_cnt  = 0;
   int unsigned stub_age  = 0;
   logic [8:0]  stub_held = '0;
   logic [8:0]  got_q[$];
   int unsigned proto_viol = 0;

   assign lif.LCD_BUSY = stub_busy;

   always @(posedge clk) begin
      if (stub_busy) begin
         stub_age++;
         if (stub_age >= 2 && lif.LCD_LOAD) proto_viol++;
         if (stub_cnt == 1) stub_busy <= 1'b0;
         stub_cnt--;
      end else if (stub_pend) begin
         if (stub_cnt == 1) begin
            stub_busy <= 1'b1;
            stub_pend = 1'b0;
            stub_cnt  = 20;
            stub_age  = 0;
            if ({lif.LCD_IS_CMD, lif.LCD_DATA} !== stub_held || !lif.LCD_LOAD) proto_viol++;
            got_q.push_back({lif.LCD_IS_CMD, lif.LCD_DATA});
         end else begin
            stub_cnt--;
         end
      end else if (lif.LCD_LOAD) begin
         stub_pend = 1'b1;
         stub_cnt  = 3;
         stub_held = {lif.LCD_IS_CMD, lif.LCD_DATA};
      end
   end

   int unsigned done_cnt = 0, err_cnt = 0, both_cnt = 0, done_early = 0;
   bit          busy_seen = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (done && lif.LCD_BUSY) done_early++;
      if (busy) busy_seen = 1'b1;
   end

   // Reference byte list built straight from the request.
   logic [8:0] exp_q[$];

   function automatic void push_coord(input int c);
      exp_q.push_back({1'b0, 8'(c / 256)});
      exp_q.push_back({1'b0, 8'(c % 256)});
   endfunction

   task automatic build_expected(input int ax0, ax1, ay0, ay1, acol, output bit rej);
      int cx1, cy1, npix;
      cx1 = ax1;
      cy1 = ay1;
      rej = 1'b0;
      exp_q.delete();
`ifdef LCD_RECT_FILL_CLIP_EN
      if (cx1 > TB_W - 1) cx1 = TB_W - 1;
      if (cy1 > TB_H - 1) cy1 = TB_H - 1;
      if (ax0 > TB_W - 1 || ay0 > TB_H - 1) rej = 1'b1;
`endif
      if (ax0 > cx1 || ay0 > cy1) rej = 1'b1;
      if (!rej) begin
         exp_q.push_back({1'b1, 8'h2A});
         push_coord(ax0);
         push_coord(cx1);
         exp_q.push_back({1'b1, 8'h2B});
         push_coord(ay0);
         push_coord(cy1);
         exp_q.push_back({1'b1, 8'h2C});
         npix = (cx1 - ax0 + 1) * (cy1 - ay0 + 1);
         for (int p = 0; p < npix; p++) begin
            exp_q.push_back({1'b0, 8'(acol / 256)});
            exp_q.push_back({1'b0, 8'(acol % 256)});
         end
      end
   endtask

   task automatic wait_lcd_quiet();
      int n = 0;
      while ((stub_busy || stub_pend) && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic pulse_start(input int ax0, ax1, ay0, ay1, acol);
      @(negedge clk);
      x0    = 9'(ax0);
      x1    = 9'(ax1);
      y0    = 9'(ay0);
      y1    = 9'(ay1);
      color = 16'(acol);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_req(input string tag, input int ax0, ax1, ay0, ay1, acol);
      bit rej, tmo;
      int bound, n, mism, first_bad;
      build_expected(ax0, ax1, ay0, ay1, acol, rej);
      wait_lcd_quiet();
      got_q.delete();
      done_cnt  = 0;
      err_cnt   = 0;
      busy_seen = 1'b0;
      pulse_start(ax0, ax1, ay0, ay1, acol);
      bound = exp_q.size() * 30 + 100;
      n     = 0;
      tmo   = 1'b1;
      while (tmo && n < bound) begin
         @(negedge clk);
         #1;
         if (done_cnt != 0 || err_cnt != 0) tmo = 1'b0;
         n++;
      end
      repeat (rej ? 40 : 3) @(negedge clk);
      check_eq({tag, "_timeout"}, 32'(tmo), 32'(0));
      check_eq({tag, "_done"}, done_cnt, rej ? 0 : 1);
      check_eq({tag, "_err"}, err_cnt, rej ? 1 : 0);
      check_eq({tag, "_busy_seen"}, 32'(busy_seen), rej ? 0 : 1);
      check_eq({tag, "_busy_end"}, 32'(busy), 32'(0));
      check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
      mism      = 0;
      first_bad = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) begin
            mism++;
            if (first_bad < 0) first_bad = i;
         end
      end
      check_eq({tag, "_byte_mismatches"}, mism, 0);
      if (first_bad >= 0)
         check_eq({tag, "_first_bad_byte"}, got_q[first_bad], exp_q[first_bad]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, h, ax0, ay0, ax1, ay1, n;
      rst           = 1'b1;
      start         = 1'b0;
      x0            = '0;
      x1            = '0;
      y0            = '0;
      y1            = '0;
      color         = '0;
      lif.LCD_READY = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_done", 32'(done), 32'(0));
      check_eq("rst_err", 32'(err), 32'(0));
      check_eq("rst_load", 32'(lif.LCD_LOAD), 32'(0));
      check_eq("rst_is_cmd", 32'(lif.LCD_IS_CMD), 32'(0));
      check_eq("rst_data", 32'(lif.LCD_DATA), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      run_req("px1x1", 5, 5, 7, 7, 16'hF800);
      run_req("rect4x3", 0, 3, 0, 2, 16'h07E0);
      run_req("rej_x", 10, 9, 0, 0, 16'h1234);
      run_req("corner", TB_W - 1, TB_W - 1, TB_H - 1, TB_H - 1, 16'hABCD);
      run_req("column", 0, 0, 250, 255, 16'h0001);

      // START while the controller is not ready must be ignored.
      lif.LCD_READY = 1'b0;
      got_q.delete();
      err_cnt   = 0;
      busy_seen = 1'b0;
      pulse_start(20, 21, 30, 31, 16'h5A5A);
      repeat (40) @(negedge clk);
      check_eq("notready_busy", 32'(busy_seen), 32'(0));
      check_eq("notready_err", err_cnt, 0);
      check_eq("notready_bytes", got_q.size(), 0);
      lif.LCD_READY = 1'b1;
      run_req("after_ready", 20, 21, 30, 31, 16'h5A5A);

      // Reset while the 5th pixel is in flight.
      wait_lcd_quiet();
      got_q.delete();
      pulse_start(0, 3, 0, 2, 16'h07E0);
      n = 0;
      while (got_q.size() < 20 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("rstmid_reached", got_q.size(), 20);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rstmid_busy", 32'(busy), 32'(0));
      check_eq("rstmid_load", 32'(lif.LCD_LOAD), 32'(0));
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check_eq("rstmid_no_more_bytes", got_q.size(), 20);
      run_req("after_rst", 100, 100, 200, 200, 16'h1F1F);

      for (int t = 0; t < 8; t++) begin
         w   = $urandom_range(1, 6);
         h   = $urandom_range(1, 6);
         ax0 = $urandom_range(0, TB_W - w);
         ay0 = $urandom_range(0, TB_H - h);
         run_req("rnd", ax0, ax0 + w - 1, ay0, ay0 + h - 1, $urandom_range(0, 65535));
      end
      for (int t = 0; t < 3; t++) begin
         ax1 = $urandom_range(0, 200);
         ay1 = $urandom_range(0, 300);
         if (t[0]) run_req("rnd_rej_y", ax1, ax1, ay1 + $urandom_range(1, 10), ay1, 16'hFFFF);
         else      run_req("rnd_rej_x", ax1 + $urandom_range(1, 10), ax1, ay1, ay1, 16'hFFFF);
      end

`ifdef LCD_RECT_FILL_CLIP_EN
      run_req("clip", 230, 300, 310, 400, 16'hC0DE);
      run_req("clip_rej", TB_W, TB_W + 5, 0, 0, 16'hC0DE);
`endif

      check_eq("done_err_overlap", both_cnt, 0);
      check_eq("done_before_lcd_idle", done_early, 0);
      check_eq("handshake_violations", proto_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
